data_memory_bytelane: RTL

- Next-generation data memory for the MIPS32 core, replacing the word-only array.
- Adds byte/halfword/word access with sign or zero extension.
- Adds a valid/ready request port with a configurable read pipeline and alignment/range fault reporting.
- Clears memory with a hardware FSM after reset, one word per cycle, instead of a single-cycle loop.
- Sits between the core's MEM stage and the word array.

---
 rtl/dmem_pkg.sv | 43 ++++
 rtl/data_memory_bytelane_lane_unit.sv | 67 ++++++
 rtl/data_memory_bytelane.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types for the byte-lane data memory.
// Request/response bundles and access-size encoding.
package dmem_pkg;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'b00,
    MEM_HALF = 2'b01,
    MEM_WORD = 2'b10
  } mem_size_e;

  typedef enum logic {
    ST_CLEAR,
    ST_IDLE
  } dmem_state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic        wen;
    mem_size_e   size;
    logic        unsigned_ld;
    logic [31:0] wdata;
  } dmem_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        fault;
  } dmem_resp_t;

  function automatic logic [31:0] ext8(
    input logic [7:0] v,
    input logic       uns
  );
    return uns ? {24'd0, v} : {{24{v[7]}}, v};
  endfunction

  function automatic logic [31:0] ext16(
    input logic [15:0] v,
    input logic        uns
  );
    return uns ? {16'd0, v} : {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/data_memory_bytelane_lane_unit.sv
// Lane steering: byte enables, store replication,
// load extraction/extension and fault detection.
module dmem_lane_unit
  import dmem_pkg::*;
#(
  parameter int IDX_W = 11
) (
  input  dmem_req_t   req_i,
  input  logic [31:0] rd_word_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] ld_data_o,
  output logic        fault_o
);

  logic [1:0]  lane;
  logic        hi_bad;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic        flt;
  logic [3:0]  be;

  assign lane   = req_i.addr[1:0];
  assign hi_bad = (req_i.addr >> (IDX_W + 2)) != 32'd0;
  assign half_v = lane[1] ? rd_word_i[31:16]
                          : rd_word_i[15:0];

  always_comb begin
    byte_v = rd_word_i[7:0];
    unique case (lane)
      2'd0: byte_v = rd_word_i[7:0];
      2'd1: byte_v = rd_word_i[15:8];
      2'd2: byte_v = rd_word_i[23:16];
      2'd3: byte_v = rd_word_i[31:24];
    endcase
  end

  always_comb begin
    flt       = hi_bad;
    be        = 4'b0000;
    wdata_o   = req_i.wdata;
    ld_data_o = rd_word_i;
    case (req_i.size)
      MEM_BYTE: begin
        be        = 4'b0001 << lane;
        wdata_o   = {4{req_i.wdata[7:0]}};
        ld_data_o = ext8(byte_v, req_i.unsigned_ld);
      end
      MEM_HALF: begin
        flt       = hi_bad | lane[0];
        be        = lane[1] ? 4'b1100 : 4'b0011;
        wdata_o   = {2{req_i.wdata[15:0]}};
        ld_data_o = ext16(half_v, req_i.unsigned_ld);
      end
      MEM_WORD: begin
        flt       = hi_bad | (lane != 2'd0);
        be        = 4'b1111;
      end
      default: flt = 1'b1;
    endcase
  end

  // Faulting or load requests must never touch the array.
  assign be_o    = (flt || !req_i.wen) ? 4'b0000 : be;
  assign fault_o = flt;

endmodule

// File: rtl/data_memory_bytelane.sv
// MEM-stage data memory with byte lanes, fault reporting,
// a hardware clear sequence and a fixed-latency response.
module data_memory_bytelane
  import dmem_pkg::*;
#(
  parameter int MEM_DEPTH      = 2048,
  parameter int READ_LATENCY   = 1,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_wen,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic        init_done
);

  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam logic [IDX_W-1:0] LAST =
    IDX_W'(MEM_DEPTH - 1);

  dmem_state_e      state_q;
  logic [IDX_W-1:0] clr_idx_q;
  logic [IDX_W-1:0] clr_idx_d;
  logic             ready_q;
  logic             done_q;

  logic [31:0] mem_q [MEM_DEPTH];

  dmem_req_t   req;
  dmem_resp_t  resp_d;
  logic [IDX_W-1:0] idx;
  logic [31:0] rd_word;
  logic [31:0] st_data;
  logic [31:0] ld_data;
  logic [3:0]  be;
  logic        fault;
  logic        accept;
  logic        clr_we;

  logic       v_q    [READ_LATENCY];
  dmem_resp_t pipe_q [READ_LATENCY];

  assign req = '{
    addr:        req_addr,
    wen:         req_wen,
    size:        mem_size_e'(req_size),
    unsigned_ld: req_unsigned,
    wdata:       req_wdata
  };

  assign idx     = req_addr[IDX_W+1:2];
  assign rd_word = mem_q[idx];
  assign accept  = req_valid & ready_q & ~reset;
  assign clr_we  = (state_q == ST_CLEAR) &
                   CLEAR_ON_RESET & ~reset;
  assign clr_idx_d = clr_idx_q + 1'b1;

  dmem_lane_unit #(
    .IDX_W(IDX_W)
  ) u_lane (
    .req_i    (req),
    .rd_word_i(rd_word),
    .be_o     (be),
    .wdata_o  (st_data),
    .ld_data_o(ld_data),
    .fault_o  (fault)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_CLEAR;
      clr_idx_q <= '0;
      ready_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      unique case (state_q)
        ST_CLEAR: begin
          clr_idx_q <= clr_idx_d;
          if (!CLEAR_ON_RESET || clr_idx_q == LAST) begin
            state_q   <= ST_IDLE;
            clr_idx_q <= '0;
            ready_q   <= 1'b1;
            done_q    <= 1'b1;
          end
        end
        ST_IDLE: begin
          ready_q <= 1'b1;
          done_q  <= 1'b1;
        end
        default: state_q <= ST_CLEAR;
      endcase
    end
  end

  // Array has no reset; the clear sequence zeroes it.
  always_ff @(posedge clock) begin
    if (clr_we) begin
      mem_q[clr_idx_q] <= '0;
    end else if (accept) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) begin
          mem_q[idx][8*b +: 8] <= st_data[8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    resp_d.fault = fault;
    resp_d.rdata = (fault || req_wen) ? 32'd0 : ld_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < READ_LATENCY; k++) begin
        v_q[k]    <= 1'b0;
        pipe_q[k] <= '0;
      end
    end else begin
      v_q[0]    <= accept;
      pipe_q[0] <= accept ? resp_d : '0;
      for (int k = 1; k < READ_LATENCY; k++) begin
        v_q[k]    <= v_q[k-1];
        pipe_q[k] <= pipe_q[k-1];
      end
    end
  end

  assign req_ready  = ready_q;
  assign init_done  = done_q;
  assign resp_valid = v_q[READ_LATENCY-1];
  assign resp_rdata = pipe_q[READ_LATENCY-1].rdata;
  assign resp_fault = pipe_q[READ_LATENCY-1].fault;

endmodule
